// File: rtl/rlnn_ctrl_pkg.sv
// Shared types and constants for the compute-unit control slice.
package rlnn_ctrl_pkg;

   localparam int CU_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      DRAIN,
      DONE
   } cu_state_t;

endpackage

// File: rtl/cu_loop_counter.sv
// Load/decrement loop counter with a zero flag; decrement saturates at zero.
module cu_loop_counter
   import rlnn_ctrl_pkg::*;
#(
   parameter int CNT_W = CU_CNT_W
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             is_zero
);

   // Load has priority over decrement; a decrement at zero leaves the count at zero.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign is_zero = (count == '0);

endmodule

// File: rtl/compute_unit_ctrl.sv
// Sequencer for the compute unit: runs R rows of K accumulation beats each and
// decodes every compute-unit control strobe from the current state.
module compute_unit_ctrl
   import rlnn_ctrl_pkg::*;
#(
   parameter int COUNT = 128,
   parameter int CNT_W = CU_CNT_W
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_chunks,
   input  logic [CNT_W-1:0] cfg_rows,
   input  logic             op_valid,
   output logic             op_ready,
   output logic             rst_accm_b,
   output logic             accm_en,
   output logic             mux_accm_inp,
   output logic             zero_operands,
   output logic             en_adder_tree,
   output logic             sipo_shift,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] row_idx
);

   cu_state_t        state;
   cu_state_t        next_state;

   logic [CNT_W-1:0] k_lat;
   logic [CNT_W-1:0] r_lat;
   logic [CNT_W-1:0] k_eff;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] rows_left;
   logic             beat_zero;
   logic             rows_zero;
   logic             latch_cfg;
   logic             beat_load;
   logic             beat_dec;
   logic             row_load;
   logic             row_dec;
   logic             last_beat;
   logic             last_row;

   // A zero-beat row still needs one beat to load the bias addend.
   assign k_eff = (cfg_chunks == '0) ? CNT_W'(1) : cfg_chunks;

   // A count of zero would only be reached after a corrupted job; treat it as last.
   assign last_beat = beat_zero || (beat_cnt == CNT_W'(1));
   assign last_row  = rows_zero || (rows_left == CNT_W'(1));

   // The row counter counts rows remaining, so the 0-based index is derived from it.
   assign row_idx = r_lat - rows_left;

   // Beats remaining in the current row.
   cu_loop_counter #(.CNT_W(CNT_W)) u_beat_cnt (
      .clk      (clk),
      .rst_b    (rst_b),
      .load     (beat_load),
      .load_val (k_lat),
      .dec      (beat_dec),
      .count    (beat_cnt),
      .is_zero  (beat_zero)
   );

   // Rows remaining in the current job.
   cu_loop_counter #(.CNT_W(CNT_W)) u_row_cnt (
      .clk      (clk),
      .rst_b    (rst_b),
      .load     (row_load),
      .load_val (cfg_rows),
      .dec      (row_dec),
      .count    (rows_left),
      .is_zero  (rows_zero)
   );

   // Job configuration is captured only when a start is accepted.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         k_lat <= '0;
         r_lat <= '0;
      end else if (latch_cfg) begin
         k_lat <= k_eff;
         r_lat <= cfg_rows;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and state-decoded strobes; abort overrides every transition.
   always_comb begin
      next_state    = state;
      op_ready      = 1'b0;
      rst_accm_b    = 1'b1;
      accm_en       = 1'b0;
      mux_accm_inp  = 1'b0;
      zero_operands = 1'b0;
      en_adder_tree = 1'b0;
      sipo_shift    = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      latch_cfg     = 1'b0;
      beat_load     = 1'b0;
      beat_dec      = 1'b0;
      row_load      = 1'b0;
      row_dec       = 1'b0;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               latch_cfg  = 1'b1;
               row_load   = 1'b1;
               next_state = (cfg_rows == '0) ? DONE : CLEAR;
            end
         end
         CLEAR: begin
            rst_accm_b = 1'b0;
            beat_load  = 1'b1;
            next_state = ACCUM;
         end
         ACCUM: begin
            // A unit built without lanes has nothing to consume.
            op_ready     = (COUNT > 0);
            accm_en      = op_valid && op_ready;
            mux_accm_inp = (beat_cnt != k_lat);
            beat_dec     = op_valid && op_ready;
            if (op_valid && op_ready && last_beat) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            zero_operands = 1'b1;
            mux_accm_inp  = 1'b1;
            en_adder_tree = 1'b1;
            sipo_shift    = 1'b1;
            row_dec       = 1'b1;
            next_state    = last_row ? DONE : CLEAR;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      if (abort) begin
         next_state = IDLE;
         latch_cfg  = 1'b0;
         beat_load  = 1'b0;
         beat_dec   = 1'b0;
         row_load   = 1'b0;
         row_dec    = 1'b0;
      end
   end

endmodule

// File: doc/compute_unit_ctrl.md
# compute_unit_ctrl

Sequencer for the compute unit (MAC array, accumulator, quantizer, adder tree, SIPO). On a start pulse it runs a programmed number of output rows; each row is a programmed number of accumulation beats pulled from an operand source via valid/ready. It drives every compute-unit control strobe: accumulator reset, enable and input mux, operand zeroing, adder-tree enable and SIPO shift. It then reports completion to the layer-level scheduler.

## Interface
- COUNT, 128: MAC lanes in the controlled compute unit (informational, passes through to the operand source).
- CNT_W, 8: width of the beat and row counters and config fields.
- clk  in  1  clock; all state changes on rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin; honoured only in IDLE.
- abort  in  1  synchronous abort; forces IDLE next cycle from any state.
- cfg_chunks  in  CNT_W  accumulation beats per row (K); sampled on accepted start.
- cfg_rows  in  CNT_W  rows per job (R); sampled on accepted start.
- op_valid  in  1  operand source has a beat on mult_inp_1/2.
- op_ready  out  1  controller consumes a beat this cycle.
- rst_accm_b  out  1  active-low accumulator clear to the compute unit.
- accm_en  out  1  accumulator capture enable.
- mux_accm_inp  out  1  0 = add_inp (bias) addend, 1 = accumulator feedback.
- zero_operands  out  1  forces multiplier operands to zero (drain cycle).
- en_adder_tree  out  1  adder-tree enable.
- sipo_shift  out  1  SIPO shift strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- row_idx  out  CNT_W  index of the row in progress (0-based).

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE: start latches K and R.
  - R = 0: go to DONE.
  - Otherwise: go to CLEAR with row_idx = 0.
  - K = 0 is treated as K = 1.
- CLEAR (1 cycle): rst_accm_b = 0; the beat counter loads K; go to ACCUM.
- ACCUM:
  - op_ready = 1 and accm_en = op_valid.
  - mux_accm_inp = 0 on the first beat of a row, 1 on later beats.
  - Each handshake (op_valid & op_ready) decrements the beat counter.
  - op_valid low: stall; the state is held and accm_en = 0.
  - Handshake on the last beat: go to DRAIN.
- DRAIN (1 cycle): zero_operands = 1, mux_accm_inp = 1, en_adder_tree = 1, sipo_shift = 1, so partial_out = accm_out and the reduced value enters the SIPO.
  - Then row_idx increments.
  - If this was row R-1, go to DONE; else go to CLEAR.
- DONE (1 cycle): done = 1; go to IDLE.
- start while busy: ignored; no queueing.
- abort: takes priority over every transition. It forces IDLE next cycle with no done pulse. The SIPO and accumulator contents are undefined afterward; the next job's CLEAR clears the accumulator.
- All strobes are decoded from the state. accm_en additionally gates on op_valid.

## Timing
- Reset values:
  - state = IDLE; row_idx = 0; beat counter = 0; latched K and R = 0.
  - rst_accm_b = 1; all other outputs = 0.
- Reset asserted mid-job: immediate return to reset values. No done pulse.
- Start accepted at cycle 0: CLEAR is at cycle 1 and the first ACCUM cycle is cycle 2.
- Without stalls, each row takes K+2 cycles. A job takes R·(K+2) cycles, and done is high in cycle R·(K+2)+1.
- Each stall cycle adds exactly one cycle. Stalls are only possible in ACCUM.
- R = 0: done is high in cycle 1 and no datapath strobe toggles.
- Counters: row_idx wraps never (bounded by R ≤ 2^CNT_W − 1). The beat counter saturates at 0.

## Structure
- Shared package rlnn_ctrl_pkg:
  - typedef enum logic [2:0] cu_state_t {IDLE, CLEAR, ACCUM, DRAIN, DONE};
  - localparam CU_CNT_W = 8.
- Sub-module cu_loop_counter: load/decrement counter with a zero flag. It is instantiated twice, once for beats and once for rows.
- All flops use negedge rst_b asynchronous reset. No datapath logic lives here.

## Test plan
- Reset: hold rst_b = 0 for 3 cycles → rst_accm_b = 1, busy = 0, done = 0, all strobes 0.
- K = 3, R = 2, op_valid tied high → 2 CLEAR pulses and 6 accm_en cycles, mux_accm_inp pattern 0,1,1 per row, 2 sipo_shift pulses, done in cycle 11.
- K = 4, R = 1, op_valid low in ACCUM cycles 2 and 3 → accm_en stays 0 during the stall, exactly 4 handshakes, done delayed by 2 cycles to cycle 9.
- R = 0 and K = 0: R = 0 → done in cycle 1 with no strobes. K = 0, R = 1 → behaves as K = 1, done in cycle 4.
- Start pulsed while busy, plus abort during ACCUM of row 1 (K = 2, R = 3) → the second start is ignored; abort gives IDLE next cycle, busy = 0, no done pulse. A fresh start then completes normally.
- Reset asserted in DRAIN → outputs take reset values asynchronously and no sipo_shift pulse is produced.
